divider_4bit_seq: RTL and testbench

//  Sequential restoring divider: unsigned dividend / divisor -> quotient, remainder.

---
 rtl/divider_4bit_seq.sv | 128 ++++++++++++
 tb/tb_divider_4bit_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/divider_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_4bit_seq
// Description : Sequential restoring divider, one trial subtraction per clock,
//               with a start/busy/done handshake.
//               Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips the
//               iterations and flags div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_4bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_ITER   = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [1:0]         c_S_IDLE = 2'd0;
    localparam logic [1:0]         c_S_RUN  = 2'd1;
    localparam logic [1:0]         c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo_work;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               w_zero_div;
    logic [WIDTH:0]     w_r_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

`ifdef DIV_ZERO_DETECT_EN
    logic r_dbz;

    assign w_zero_div  = (divisor == '0);
    assign div_by_zero = r_dbz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbz <= 1'b0;
        end else if (r_state == c_S_IDLE && start) begin
            r_dbz <= w_zero_div;
        end
    end
`else
    assign w_zero_div  = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    // Restored remainder is always below the divisor, so WIDTH bits hold it
    // and the shifted value only needs one extra bit for the trial.
    assign w_r_shift  = {r_rem, r_quo_work[WIDTH-1]};
    assign w_trial    = w_r_shift - {1'b0, r_divisor};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo_work[WIDTH-2:0], w_fits};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_state_next = w_zero_div ? c_S_DONE : c_S_RUN;
            c_S_RUN:  if (r_cnt == c_ONE) w_state_next = c_S_DONE;
            c_S_DONE: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo_work  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_divisor  <= divisor;
                        r_quo_work <= dividend;
                        r_rem      <= '0;
                        r_cnt      <= c_ITER;
                        if (w_zero_div) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
                    end
                end
                c_S_RUN: begin
                    r_rem      <= w_rem_next;
                    r_quo_work <= w_quo_next;
                    r_cnt      <= r_cnt - c_ONE;
                    // Results publish only on the final iteration.
                    if (r_cnt == c_ONE) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == c_S_RUN);
    assign done      = (r_state == c_S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_divider_4bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_4bit_seq
// Description : Directed self-checking bench for divider_4bit_seq; honours
//               DIV_ZERO_DETECT_EN when the macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_4bit_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam int c_DZ = 1;
`else
    localparam int c_DZ = 0;
`endif

    divider_4bit_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full operation from IDLE; leaves the DUT back in IDLE.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input int eq, input int er, input int ebz, input int elat);
        logic [3:0] q_prev;
        int lat;
        int busy_cycles;
        @(negedge clk);
        q_prev   = quotient;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start       = 1'b0;
        dividend    = ~a;
        divisor     = ~b;
        lat         = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            if (lat == 1) chk({tag, " q_held"}, quotient, q_prev);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy_cycles"}, busy_cycles, elat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ebz);
        chk({tag, " busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int dcnt;
        int dlat;
        int d_first;
        int d_second;
        logic [3:0] qv;
        logic [3:0] rv;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst div_by_zero", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("13/3", 4'd13, 4'd3, 4, 1, 0, 4);
        run_op("15/1", 4'd15, 4'd1, 15, 0, 0, 4);
        run_op("2/7", 4'd2, 4'd7, 0, 2, 0, 4);
        run_op("0/5", 4'd0, 4'd5, 0, 0, 0, 4);
        run_op("9/0", 4'd9, 4'd0, 15, 9, c_DZ, (c_DZ != 0) ? 0 : 4);
        run_op("8/2", 4'd8, 4'd2, 4, 0, 0, 4);

        // Start and operand changes while busy are ignored.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk); #1;
        dcnt = 0; dlat = -1; qv = 4'd0; rv = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                start = 1'b1; dividend = 4'd7; divisor = 4'd2;
            end else begin
                start = 1'b0; dividend = 4'd15; divisor = 4'd1;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dcnt++;
                if (dlat < 0) dlat = k;
                qv = quotient;
                rv = remainder;
            end
        end
        chk("busy_ignore done_count", dcnt, 1);
        chk("busy_ignore latency", dlat, 4);
        chk("busy_ignore quotient", qv, 2);
        chk("busy_ignore remainder", rv, 2);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        chk("midrst div_by_zero", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op("6/4 after reset", 4'd6, 4'd4, 1, 2, 0, 4);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(posedge clk); #1;
        dcnt = 0; d_first = -1; d_second = -1; qv = 4'd0; rv = 4'd0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dcnt++;
                if (d_first < 0) d_first = k;
                else if (d_second < 0) begin
                    d_second = k;
                    qv = quotient;
                    rv = remainder;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("b2b done_count", dcnt, 2);
        chk("b2b first_done", d_first, 4);
        chk("b2b spacing", d_second - d_first, 6);
        chk("b2b quotient", qv, 3);
        chk("b2b remainder", rv, 2);
        repeat (8) @(posedge clk);
        #1;

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op("sweep", 4'(a), 4'(b), a / b, a % b, 0, 4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
